// File: rtl/registers_pkg.sv
// Shared types and defaults for the general-purpose register file.
package registers_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 5;

    typedef logic [DATA_W-1:0] reg_data_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    localparam reg_data_t REG_RST_VAL = '0;

endpackage

// File: rtl/registers_if.sv
// Decode/writeback side of the register file: two read ports, one write port.
interface registers_if #(
    parameter int DATA_W = registers_pkg::DATA_W,
    parameter int ADDR_W = registers_pkg::ADDR_W
);

    logic [DATA_W-1:0] Rdst;
    logic [DATA_W-1:0] Rsrc1;
    logic [DATA_W-1:0] Rsrc2;
    logic [ADDR_W-1:0] Rdst_addr;
    logic [ADDR_W-1:0] Rsrc1_addr;
    logic [ADDR_W-1:0] Rsrc2_addr;
    logic              Rwrite;

    modport master (
        output Rdst, Rdst_addr, Rwrite,
        output Rsrc1_addr, Rsrc2_addr,
        input  Rsrc1, Rsrc2
    );

    modport slave (
        input  Rdst, Rdst_addr, Rwrite,
        input  Rsrc1_addr, Rsrc2_addr,
        output Rsrc1, Rsrc2
    );

endinterface

// File: rtl/registers_rd_port.sv
// Combinational read mux; REG_ZERO_HARDWIRED_EN forces address 0 to read 0.
module registers_rd_port #(
    parameter int DATA_W = registers_pkg::DATA_W,
    parameter int ADDR_W = registers_pkg::ADDR_W
) (
    input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] o_data
);

`ifdef REG_ZERO_HARDWIRED_EN
    // Masked here so R0 reads 0 even before the first reset.
    assign o_data = (i_addr == '0) ? '0 : i_regs[i_addr];
`else
    assign o_data = i_regs[i_addr];
`endif

endmodule

// File: rtl/registers.sv
// 2**ADDR_W x DATA_W register file, sync write, two async reads.
// REG_ZERO_HARDWIRED_EN: entry 0 is constant zero.
module registers #(
    parameter int DATA_W = registers_pkg::DATA_W,
    parameter int ADDR_W = registers_pkg::ADDR_W
) (
    input  logic       clk,
    input  logic       rst,
    registers_if.slave bus
);

    import registers_pkg::*;

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;

`ifdef REG_ZERO_HARDWIRED_EN
    assign w_wr_en = bus.Rwrite && (bus.Rdst_addr != '0);
`else
    assign w_wr_en = bus.Rwrite;
`endif

    // Reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DATA_W'(REG_RST_VAL);
            end
        end else if (w_wr_en) begin
            r_mem[bus.Rdst_addr] <= bus.Rdst;
        end
    end

    registers_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd1 (
        .i_regs (r_mem),
        .i_addr (bus.Rsrc1_addr),
        .o_data (bus.Rsrc1)
    );

    registers_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rd2 (
        .i_regs (r_mem),
        .i_addr (bus.Rsrc2_addr),
        .o_data (bus.Rsrc2)
    );

endmodule

// File: tb/tb_registers.sv
// Scoreboard bench for the register file: directed plan plus random traffic.
module tb_registers;

    import registers_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    registers_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    registers #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned model [DEPTH];
    bit          model_valid = 1'b0;

    int unsigned q_exp1 [$];
    int unsigned q_exp2 [$];
    string       q_tag  [$];

    int checks = 0;
    int errors = 0;

    function automatic int unsigned ref_read(int a);
`ifdef REG_ZERO_HARDWIRED_EN
        if (a == 0) return 0;
`endif
        return model[a];
    endfunction

    // Called at posedge+1: drive, queue expected reads, then follow the edge.
    task automatic cycle(input string tag, input bit r, input bit we,
                         input int wa, input int wd,
                         input int a1, input int a2);
        rst            = r;
        bus.Rwrite     = we;
        bus.Rdst_addr  = AW'(wa);
        bus.Rdst       = DW'(wd);
        bus.Rsrc1_addr = AW'(a1);
        bus.Rsrc2_addr = AW'(a2);
        if (model_valid) begin
            q_exp1.push_back(ref_read(a1));
            q_exp2.push_back(ref_read(a2));
            q_tag.push_back(tag);
        end
        @(posedge clk);
        if (r) begin
            foreach (model[i]) model[i] = 0;
            model_valid = 1'b1;
        end else if (we) begin
`ifdef REG_ZERO_HARDWIRED_EN
            if (wa != 0) model[wa] = wd & 16'hFFFF;
`else
            model[wa] = wd & 16'hFFFF;
`endif
        end
        #1;
    endtask

    // Monitor: read data is valid every cycle once inputs settle.
    always @(negedge clk) begin
        if (q_exp1.size() > 0) begin
            int unsigned e1, e2;
            string t;
            e1 = q_exp1.pop_front();
            e2 = q_exp2.pop_front();
            t  = q_tag.pop_front();
            checks += 2;
            if (32'(bus.Rsrc1) !== e1) begin
                errors++;
                $display("FAIL %s Rsrc1: got %h expected %h", t, bus.Rsrc1, e1[15:0]);
            end
            if (32'(bus.Rsrc2) !== e2) begin
                errors++;
                $display("FAIL %s Rsrc2: got %h expected %h", t, bus.Rsrc2, e2[15:0]);
            end
        end
    end

    initial begin
        int n;
        bus.Rwrite     = 1'b0;
        bus.Rdst       = '0;
        bus.Rdst_addr  = '0;
        bus.Rsrc1_addr = '0;
        bus.Rsrc2_addr = '0;
        @(posedge clk);
        #1;

        cycle("reset",      1, 0, 0, 0,       0, 0);
        cycle("rst_read",   0, 0, 0, 0,       5, 31);
        cycle("wr_r1_47",   0, 1, 1, 47,      1, 2);
        cycle("wr_r2_47",   0, 1, 2, 47,      1, 2);
        cycle("wr_r2_74",   0, 1, 2, 74,      1, 2);
        cycle("rd_r1_r2",   0, 0, 0, 0,       1, 2);
        for (int i = 0; i < 3; i++)
            cycle("wr_disable", 0, 0, 1, 'hFFFF, 1, 2);
        cycle("wdis_read",  0, 0, 0, 0,       1, 1);
        cycle("wr_r3_10",   0, 1, 3, 10,      3, 0);
        cycle("same_cyc",   0, 1, 3, 20,      3, 3);
        cycle("after_edge", 0, 0, 0, 0,       3, 3);
        cycle("rst_prio",   1, 1, 4, 99,      4, 1);
        cycle("post_rst",   0, 0, 0, 0,       4, 1);
        cycle("post_rst2",  0, 0, 0, 0,       2, 3);
        cycle("wr_r0",      0, 1, 0, 'h1234,  0, 0);
        cycle("rd_r0",      0, 0, 0, 0,       0, 0);

        for (int i = 0; i < 400; i++) begin
            n = int'($urandom_range(0, 39));
            cycle("random", n == 0, $urandom_range(0, 2) != 0,
                  int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, 16'hFFFF)),
                  int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, DEPTH - 1)));
        end
        cycle("final_rd",   0, 0, 0, 0,       1, 2);

        for (int i = 0; i < 10 && q_exp1.size() > 0; i++) @(posedge clk);
        if (q_exp1.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d reads left unchecked, expected 0", q_exp1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
